// File: rtl/db_pkg.sv
// Shared definitions for the switch debouncer: FSM state encoding and default timing.
package db_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_e;

  localparam int DB_STABLE_CYCLES = 20;
  localparam int DB_CNT_W         = 5;

endpackage

// File: rtl/db_fsm_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; q is the second stage.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_r;
  logic s2_r;

  // Only s1_r may go metastable; s2_r gives it a full cycle to resolve.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/db_fsm_debouncer.sv
// Switch debouncer: synchronizes sw, then requires STABLE_CYCLES+1 consistent
// samples before changing db_level, with one-cycle rise/fall ticks.
module db_fsm_debouncer
  import db_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
  parameter int CNT_W         = DB_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             s2_s;
  db_state_e        state_r;
  db_state_e        state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             db_level_r;
  logic             db_level_s;
  logic             rise_r;
  logic             rise_s;
  logic             fall_r;
  logic             fall_s;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sw),
    .q       (s2_s)
  );

  // State, stability counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ZERO;
      cnt_r      <= CNT_ZERO;
      db_level_r <= 1'b0;
      rise_r     <= 1'b0;
      fall_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      db_level_r <= db_level_s;
      rise_r     <= rise_s;
      fall_r     <= fall_s;
    end
  end

  // Next-state logic; an opposite sample in a WAIT state aborts without a tick.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    db_level_s = db_level_r;
    rise_s     = 1'b0;
    fall_s     = 1'b0;
    case (state_r)
      ZERO: begin
        if (s2_s) begin
          state_s = WAIT1;
          cnt_s   = CNT_RELOAD;
        end else begin
          state_s = ZERO;
        end
      end
      WAIT1: begin
        if (!s2_s) begin
          state_s = ZERO;
        end else if (cnt_r == CNT_ZERO) begin
          state_s    = ONE;
          db_level_s = 1'b1;
          rise_s     = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ONE: begin
        if (!s2_s) begin
          state_s = WAIT0;
          cnt_s   = CNT_RELOAD;
        end else begin
          state_s = ONE;
        end
      end
      WAIT0: begin
        if (s2_s) begin
          state_s = ONE;
        end else if (cnt_r == CNT_ZERO) begin
          state_s    = ZERO;
          db_level_s = 1'b0;
          fall_s     = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s    = ZERO;
        cnt_s      = CNT_ZERO;
        db_level_s = 1'b0;
      end
    endcase
  end

  assign db_level  = db_level_r;
  assign rise_tick = rise_r;
  assign fall_tick = fall_r;

endmodule
